// File: rtl/vpipe_decode_pipe_if.sv
// vpipe_decode_pipe_if: valid/ready bus for the decode pipe, including the tag-tracking outputs.
// err_sticky exists only when VPIPE_DEC_STICKY_ERR_EN is defined.
interface vpipe_decode_pipe_if #(parameter int WIDTH = 4, parameter int LAT_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             out_tag;
  logic             tag_done;
  logic [LAT_W-1:0] tag_lat;
  logic             tag_drop;
`ifdef VPIPE_DEC_STICKY_ERR_EN
  logic             err_sticky;
`endif
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_tag, tag_done, tag_lat, tag_drop
`ifdef VPIPE_DEC_STICKY_ERR_EN
    , input err_sticky
`endif
  );
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_err, out_tag, tag_done, tag_lat, tag_drop
`ifdef VPIPE_DEC_STICKY_ERR_EN
    , output err_sticky
`endif
  );
endinterface

// File: rtl/vpipe_decode_pipe.sv
// vpipe_decode_pipe: 3-stage elastic decoder (x -> x>>1, error on LSB 0) with single-tag latency tracking.
// Define VPIPE_DEC_STICKY_ERR_EN to add err_sticky, which blocks new input after any errored item exits.
module vpipe_decode_pipe #(
  parameter int WIDTH = 4,
  parameter int LAT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  vpipe_decode_pipe_if.slave bus
);
  logic [2:0]       r_v, r_e, r_t;
  logic [WIDTH-1:0] r_d [3];
  logic             r_busy;
  logic [LAT_W-1:0] r_lat;
  logic [2:0]       w_ld;
  logic             w_block, w_acc, w_out_hs, w_tag_exit, w_take;
  logic [LAT_W-1:0] w_lat_inc;
  // load chain is combinational back to front, so a streaming pipe never bubbles
  assign w_ld[2]    = ~r_v[2] | bus.out_ready;
  assign w_ld[1]    = ~r_v[1] | w_ld[2];
  assign w_ld[0]    = ~r_v[0] | w_ld[1];
  assign bus.in_ready = w_ld[0] & ~w_block;
  assign w_acc      = bus.in_valid & bus.in_ready;
  assign w_out_hs   = r_v[2] & bus.out_ready;
  assign w_tag_exit = w_out_hs & r_t[2];
  // a tag leaving this cycle frees the tracker for a tag arriving this cycle
  assign w_take     = w_acc & bus.in_tag & ~(r_busy & ~w_tag_exit);
  assign w_lat_inc  = &r_lat ? r_lat : r_lat + 1'b1;
  assign bus.out_valid = r_v[2];
  assign bus.out_data  = r_d[2];
  assign bus.out_err   = r_e[2];
  assign bus.out_tag   = r_t[2];
  assign bus.tag_done  = w_tag_exit;
  assign bus.tag_lat   = w_tag_exit ? w_lat_inc : '0;
  assign bus.tag_drop  = w_acc & bus.in_tag & ~w_take;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_e    <= '0;
      r_t    <= '0;
      r_d    <= '{default: '0};
      r_busy <= 1'b0;
      r_lat  <= '0;
    end else begin
      if (w_ld[0]) begin
        r_v[0] <= w_acc;
        r_d[0] <= bus.in_data >> 1;
        r_e[0] <= ~bus.in_data[0];
        r_t[0] <= w_take;
      end
      for (int k = 1; k < 3; k++) begin
        if (w_ld[k]) begin
          r_v[k] <= r_v[k-1];
          r_d[k] <= r_d[k-1] >> 1;
          r_e[k] <= r_e[k-1] | ~r_d[k-1][0];
          r_t[k] <= r_t[k-1];
        end
      end
      if (w_take) begin
        r_busy <= 1'b1;
        r_lat  <= '0;
      end else begin
        if (w_tag_exit) r_busy <= 1'b0;
        if (r_busy) r_lat <= w_lat_inc;
      end
    end
  end
`ifdef VPIPE_DEC_STICKY_ERR_EN
  logic r_sticky;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sticky <= 1'b0;
    else if (w_out_hs & r_e[2]) r_sticky <= 1'b1;
  end
  assign bus.err_sticky = r_sticky;
  assign w_block = r_sticky;
`else
  assign w_block = 1'b0;
`endif
endmodule

// File: tb/tb_vpipe_decode_pipe.sv
// tb_vpipe_decode_pipe: directed checks of streaming, backpressure, tag tracking and reset of the decode pipe.
module tb_vpipe_decode_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  vpipe_decode_pipe_if #(.WIDTH(4), .LAT_W(4)) bus ();
  vpipe_decode_pipe #(.WIDTH(4), .LAT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_tag    = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid act=%b exp=0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out_data !== 4'h0) $display("FAIL reset_out_data act=%h exp=0", bus.out_data); else n_pass++;
    n_chk++; if (bus.out_err !== 1'b0) $display("FAIL reset_out_err act=%b exp=0", bus.out_err); else n_pass++;
    n_chk++; if (bus.out_tag !== 1'b0) $display("FAIL reset_out_tag act=%b exp=0", bus.out_tag); else n_pass++;
    n_chk++; if (bus.tag_done !== 1'b0) $display("FAIL reset_tag_done act=%b exp=0", bus.tag_done); else n_pass++;
    n_chk++; if (bus.tag_lat !== 4'h0) $display("FAIL reset_tag_lat act=%h exp=0", bus.tag_lat); else n_pass++;
    n_chk++; if (bus.tag_drop !== 1'b0) $display("FAIL reset_tag_drop act=%b exp=0", bus.tag_drop); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready act=%b exp=1", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    logic [3:0] din [3];
    logic [3:0] ed [3];
    logic       ee [3];
    din = '{4'hF, 4'h7, 4'hB};
    ed  = '{4'h1, 4'h0, 4'h1};
    ee  = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      bus.in_valid = (c < 3);
      bus.in_data  = (c < 3) ? din[c] : 4'h0;
      #1;
      if (c < 3) begin
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d act=%b exp=1", c, bus.in_ready); else n_pass++;
      end
      if (c >= 3 && c < 6) begin
        n_chk++; if (bus.out_valid !== 1'b1) $display("FAIL stream_out_valid c=%0d act=%b exp=1", c, bus.out_valid); else n_pass++;
        n_chk++; if (bus.out_data !== ed[c-3]) $display("FAIL stream_out_data c=%0d act=%h exp=%h", c, bus.out_data, ed[c-3]); else n_pass++;
        n_chk++; if (bus.out_err !== ee[c-3]) $display("FAIL stream_out_err c=%0d act=%b exp=%b", c, bus.out_err, ee[c-3]); else n_pass++;
      end
      if (c == 6) begin
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL stream_drained act=%b exp=0", bus.out_valid); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] din [4];
    logic [3:0] ed [4];
    logic       ee [4];
    int idx, oidx;
    logic acc, hs;
    din = '{4'hF, 4'hB, 4'hD, 4'h3};
    ed  = '{4'h1, 4'h1, 4'h1, 4'h0};
    ee  = '{1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0;
    oidx = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      bus.out_ready = (c >= 5);
      bus.in_valid  = (idx < 4);
      bus.in_data   = (idx < 4) ? din[idx] : 4'h0;
      #1;
      if (c == 3) begin
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_full act=%b exp=0", bus.in_ready); else n_pass++;
      end
      if (c == 4) begin
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h1) $display("FAIL bp_stall_hold act=%b/%h exp=1/1", bus.out_valid, bus.out_data); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (idx !== 3) $display("FAIL bp_accepts_before_release act=%0d exp=3", idx); else n_pass++;
      end
      acc = bus.in_valid & bus.in_ready;
      hs  = bus.out_valid & bus.out_ready;
      if (hs) begin
        if (oidx < 4) begin
          n_chk++; if (bus.out_data !== ed[oidx] || bus.out_err !== ee[oidx]) $display("FAIL bp_out item=%0d act=%h/%b exp=%h/%b", oidx, bus.out_data, bus.out_err, ed[oidx], ee[oidx]); else n_pass++;
        end else begin
          n_chk++; $display("FAIL bp_extra_output item=%0d act=%h exp=none", oidx, bus.out_data);
        end
        oidx++;
      end
      tick();
      if (acc) idx++;
    end
    n_chk++; if (idx !== 4) $display("FAIL bp_total_accepts act=%0d exp=4", idx); else n_pass++;
    n_chk++; if (oidx !== 4) $display("FAIL bp_total_outputs act=%0d exp=4", oidx); else n_pass++;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_tag;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = (c == 0);
      bus.in_tag   = (c == 0);
      bus.in_data  = 4'hF;
      #1;
      if (c == 2 || c == 4) begin
        n_chk++; if (bus.tag_done !== 1'b0) $display("FAIL tag_done_idle c=%0d act=%b exp=0", c, bus.tag_done); else n_pass++;
      end
      if (c == 3) begin
        n_chk++; if (bus.tag_done !== 1'b1) $display("FAIL tag_done act=%b exp=1", bus.tag_done); else n_pass++;
        n_chk++; if (bus.tag_lat !== 4'd3) $display("FAIL tag_lat act=%0d exp=3", bus.tag_lat); else n_pass++;
        n_chk++; if (bus.out_tag !== 1'b1) $display("FAIL tag_out_tag act=%b exp=1", bus.out_tag); else n_pass++;
      end
      tick();
    end
    for (int c = 0; c < 7; c++) begin
      bus.in_valid  = (c == 0);
      bus.in_tag    = (c == 0);
      bus.in_data   = 4'hF;
      bus.out_ready = !(c == 3 || c == 4);
      #1;
      if (c == 3) begin
        n_chk++; if (bus.tag_done !== 1'b0) $display("FAIL tag_stall_no_done act=%b exp=0", bus.tag_done); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (bus.tag_done !== 1'b1) $display("FAIL tag_stall_done act=%b exp=1", bus.tag_done); else n_pass++;
        n_chk++; if (bus.tag_lat !== 4'd5) $display("FAIL tag_stall_lat act=%0d exp=5", bus.tag_lat); else n_pass++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_collision;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c == 0 || c == 1 || c == 3);
      bus.in_tag   = (c <= 3);
      bus.in_data  = (c == 0) ? 4'hF : (c == 1) ? 4'h7 : 4'hB;
      #1;
      if (c == 1) begin
        n_chk++; if (bus.tag_drop !== 1'b1) $display("FAIL coll_drop act=%b exp=1", bus.tag_drop); else n_pass++;
      end
      if (c == 2) begin
        n_chk++; if (bus.tag_drop !== 1'b0) $display("FAIL coll_no_accept_drop act=%b exp=0", bus.tag_drop); else n_pass++;
      end
      if (c == 3) begin
        n_chk++; if (bus.tag_drop !== 1'b0) $display("FAIL coll_swap_drop act=%b exp=0", bus.tag_drop); else n_pass++;
        n_chk++; if (bus.tag_done !== 1'b1 || bus.tag_lat !== 4'd3) $display("FAIL coll_first_exit act=%b/%0d exp=1/3", bus.tag_done, bus.tag_lat); else n_pass++;
      end
      if (c == 4) begin
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 1'b0 || bus.out_data !== 4'h0) $display("FAIL coll_untagged_item act=%b/%b/%h exp=1/0/0", bus.out_valid, bus.out_tag, bus.out_data); else n_pass++;
        n_chk++; if (bus.tag_done !== 1'b0) $display("FAIL coll_untagged_done act=%b exp=0", bus.tag_done); else n_pass++;
      end
      if (c == 6) begin
        n_chk++; if (bus.out_tag !== 1'b1 || bus.out_data !== 4'h1) $display("FAIL coll_second_item act=%b/%h exp=1/1", bus.out_tag, bus.out_data); else n_pass++;
        n_chk++; if (bus.tag_done !== 1'b1 || bus.tag_lat !== 4'd3) $display("FAIL coll_second_exit act=%b/%0d exp=1/3", bus.tag_done, bus.tag_lat); else n_pass++;
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstream;
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_tag   = (c == 0);
      bus.in_data  = (c == 0) ? 4'hF : (c == 1) ? 4'h7 : 4'hB;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_tag   = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL mid_full act=%b/%b/%b exp=1/1/0", bus.out_valid, bus.out_tag, bus.in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid act=%b exp=0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out_data !== 4'h0) $display("FAIL mid_rst_out_data act=%h exp=0", bus.out_data); else n_pass++;
    n_chk++; if (bus.out_tag !== 1'b0) $display("FAIL mid_rst_out_tag act=%b exp=0", bus.out_tag); else n_pass++;
    n_chk++; if (bus.out_err !== 1'b0) $display("FAIL mid_rst_out_err act=%b exp=0", bus.out_err); else n_pass++;
    n_chk++; if (bus.tag_done !== 1'b0 || bus.tag_lat !== 4'h0 || bus.tag_drop !== 1'b0) $display("FAIL mid_rst_tag act=%b/%h/%b exp=0/0/0", bus.tag_done, bus.tag_lat, bus.tag_drop); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_in_ready act=%b exp=1", bus.in_ready); else n_pass++;
    tick();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_sticky;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (c == 0);
      bus.in_data  = 4'h2;
      #1;
      if (c == 3) begin
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_data !== 4'h0) $display("FAIL sticky_item act=%b/%b/%h exp=1/1/0", bus.out_valid, bus.out_err, bus.out_data); else n_pass++;
`ifdef VPIPE_DEC_STICKY_ERR_EN
        n_chk++; if (bus.err_sticky !== 1'b0) $display("FAIL sticky_before_exit act=%b exp=0", bus.err_sticky); else n_pass++;
`endif
      end
      if (c == 5) begin
`ifdef VPIPE_DEC_STICKY_ERR_EN
        n_chk++; if (bus.err_sticky !== 1'b1) $display("FAIL sticky_set act=%b exp=1", bus.err_sticky); else n_pass++;
        n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL sticky_in_ready act=%b exp=0", bus.in_ready); else n_pass++;
`else
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL nosticky_in_ready act=%b exp=1", bus.in_ready); else n_pass++;
`endif
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_tag();
    test_collision();
    test_reset_midstream();
    test_sticky();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
